// File: rtl/us_fault_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : us_fault_pkg
//  Description : Shared types and constants for the ultrasonic fault monitor:
//                ranger / detector state encodings, ASCII report constants
//                and the report prefix bytes.
//  Revision    : 1.0 - initial release
// ============================================================================
package us_fault_pkg;

    // Ranger sequencing: trigger, wait for echo, measure echo, evaluate.
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        TRIG      = 3'd1,
        WAIT_RISE = 3'd2,
        MEASURE   = 3'd3,
        EVAL      = 3'd4
    } ranger_state_t;

    // Debounced proximity state.
    typedef enum logic [0:0] {
        FAR  = 1'b0,
        NEAR = 1'b1
    } det_state_t;

    localparam logic [7:0] ASCII_0    = 8'h30;
    localparam logic [7:0] ASCII_HASH = 8'h23;

    localparam int PREFIX_MAX = 8;

    // "FIM-CSU1"
    localparam logic [7:0] PREFIX [0:PREFIX_MAX-1] = '{
        8'h46, 8'h49, 8'h4D, 8'h2D, 8'h43, 8'h53, 8'h55, 8'h31
    };

    function automatic logic [7:0] prefix_byte(input logic [2:0] idx);
        return PREFIX[idx];
    endfunction

endpackage : us_fault_pkg
`default_nettype wire

// File: rtl/msg_streamer.sv
`default_nettype none
// ============================================================================
//  Module      : msg_streamer
//  Description : Streams one ASCII fault report per request over a valid/ready
//                byte interface: PREFIX[0..PREFIX_LEN-1], '0'+count, '#'.
//                One request may queue behind the active report; any further
//                request while queued is dropped and raises a sticky overflow.
//  Ports       : clk, rst        - clock, synchronous active-high reset
//                i_req, i_count  - report request and fault count to print
//                i_ready         - consumer accepts o_data when o_valid
//                o_data, o_valid - report byte stream
//                o_busy          - report active or queued
//                o_overflow      - sticky, a request was dropped
//  Revision    : 1.0 - initial release
// ============================================================================
module msg_streamer
    import us_fault_pkg::*;
#(
    parameter int PREFIX_LEN = 8
)(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_req,
    input  logic [3:0] i_count,
    input  logic       i_ready,
    output logic [7:0] o_data,
    output logic       o_valid,
    output logic       o_busy,
    output logic       o_overflow
);

    localparam logic [3:0] c_digit_idx = 4'(PREFIX_LEN);
    localparam logic [3:0] c_last_idx  = 4'(PREFIX_LEN + 1);

    logic       r_active;
    logic [3:0] r_idx;
    logic [3:0] r_count;
    logic       r_pend;
    logic [3:0] r_pend_count;
    logic       r_overflow;

    logic       w_hs;
    logic       w_last_hs;
    logic [7:0] w_data;

    assign w_hs      = r_active & i_ready;
    assign w_last_hs = w_hs & (r_idx == c_last_idx);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_active     <= 1'b0;
            r_idx        <= 4'd0;
            r_count      <= 4'd0;
            r_pend       <= 1'b0;
            r_pend_count <= 4'd0;
            r_overflow   <= 1'b0;
        end else if (!r_active) begin
            // The pending slot is only ever filled while active, so an idle
            // streamer never has a queued report.
            if (i_req) begin
                r_active <= 1'b1;
                r_idx    <= 4'd0;
                r_count  <= i_count;
            end
        end else begin
            if (w_hs) begin
                if (r_idx == c_last_idx) begin
                    if (r_pend) begin
                        r_idx   <= 4'd0;
                        r_count <= r_pend_count;
                        r_pend  <= 1'b0;
                    end else if (i_req) begin
                        // Request coinciding with the final byte: behaves as
                        // queued-then-started, with no idle cycle in between.
                        r_idx   <= 4'd0;
                        r_count <= i_count;
                    end else begin
                        r_active <= 1'b0;
                    end
                end else begin
                    r_idx <= r_idx + 1'b1;
                end
            end
            if (i_req) begin
                if (r_pend) begin
                    r_overflow <= 1'b1;
                end else if (!w_last_hs) begin
                    r_pend       <= 1'b1;
                    r_pend_count <= i_count;
                end
            end
        end
    end

    // Byte is a pure function of registered index/count, so it holds steady
    // for as long as the consumer stalls.
    always_comb begin
        w_data = 8'h00;
        if (r_active) begin
            if (r_idx < c_digit_idx) begin
                w_data = prefix_byte(r_idx[2:0]);
            end else if (r_idx == c_digit_idx) begin
                w_data = ASCII_0 + {4'h0, r_count};
            end else begin
                w_data = ASCII_HASH;
            end
        end
    end

    assign o_data     = w_data;
    assign o_valid    = r_active;
    assign o_busy     = r_active | r_pend;
    assign o_overflow = r_overflow;

endmodule : msg_streamer
`default_nettype wire

// File: rtl/us_fault_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : us_fault_monitor
//  Description : Ultrasonic ranger with hysteresis/confirmation proximity
//                detector. Schedules trigger pulses, measures echo width with
//                timeout, debounces near/far and on each confirmed far->near
//                edge strobes fault_detect and streams an ASCII report.
//  Ports       : clk_50M, reset          - clock, synchronous active-high reset
//                UV_echo / UV_trig       - sensor echo input / trigger output
//                echo_width, width_valid - last valid width and its strobe
//                echo_timeout            - strobe on timed-out measurement
//                in_box                  - debounced near state
//                fault_detect            - strobe on confirmed far->near
//                fault_count             - decimal fault counter, 0..9
//                msg_data/valid/ready    - report byte stream
//                msg_busy, msg_overflow  - report status
//  Revision    : 1.0 - initial release
// ============================================================================
module us_fault_monitor
    import us_fault_pkg::*;
#(
    parameter int TRIG_CYCLES    = 500,
    parameter int PERIOD_CYCLES  = 3000000,
    parameter int TIMEOUT_CYCLES = 1200000,
    parameter int CNT_W          = 22,
    parameter int NEAR_THRESH    = 16500,
    parameter int FAR_THRESH     = 18000,
    parameter int CONFIRM        = 2,
    parameter int PREFIX_LEN     = 8
)(
    input  logic             clk_50M,
    input  logic             reset,
    input  logic             UV_echo,
    output logic             UV_trig,
    output logic [CNT_W-1:0] echo_width,
    output logic             width_valid,
    output logic             echo_timeout,
    output logic             in_box,
    output logic             fault_detect,
    output logic [3:0]       fault_count,
    output logic [7:0]       msg_data,
    output logic             msg_valid,
    input  logic             msg_ready,
    output logic             msg_busy,
    output logic             msg_overflow
);

    localparam int CONF_W = (CONFIRM < 1) ? 1 : $clog2(CONFIRM + 1);

    localparam logic [CNT_W-1:0]  c_period_last  = CNT_W'(PERIOD_CYCLES - 1);
    localparam logic [CNT_W-1:0]  c_trig_last    = CNT_W'(TRIG_CYCLES - 1);
    localparam logic [CNT_W-1:0]  c_timeout_last = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0]  c_timeout      = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0]  c_near         = CNT_W'(NEAR_THRESH);
    localparam logic [CNT_W-1:0]  c_far          = CNT_W'(FAR_THRESH);
    localparam logic [CONF_W-1:0] c_conf_last    = CONF_W'(CONFIRM - 1);

    // ------------------------------------------------------------------
    // Echo synchroniser
    // ------------------------------------------------------------------
    logic r_echo_meta;
    logic r_echo_s;

    always_ff @(posedge clk_50M) begin
        if (reset) begin
            r_echo_meta <= 1'b0;
            r_echo_s    <= 1'b0;
        end else begin
            r_echo_meta <= UV_echo;
            r_echo_s    <= r_echo_meta;
        end
    end

    // ------------------------------------------------------------------
    // Ranger FSM
    // ------------------------------------------------------------------
    ranger_state_t    r_state;
    ranger_state_t    w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] r_period_cnt;
    logic             r_first;
    logic             w_trig_start;
    logic             w_sample_ok;
    logic             w_sample_to;
    logic [CNT_W-1:0] r_echo_width;
    logic             r_width_valid;
    logic             r_echo_timeout;

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_trig_start = 1'b0;
        w_sample_ok  = 1'b0;
        w_sample_to  = 1'b0;
        case (r_state)
            IDLE: begin
                // The period counter saturates, so an overrun period starts
                // the next trigger on the first idle cycle.
                if (r_first || (r_period_cnt == c_period_last)) begin
                    w_state_nxt  = TRIG;
                    w_cnt_nxt    = '0;
                    w_trig_start = 1'b1;
                end
            end
            TRIG: begin
                if (r_cnt == c_trig_last) begin
                    w_state_nxt = WAIT_RISE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            WAIT_RISE: begin
                if (r_echo_s) begin
                    // The rising cycle itself is the first counted high cycle.
                    w_state_nxt = MEASURE;
                    w_cnt_nxt   = CNT_W'(1);
                end else if (r_cnt == c_timeout_last) begin
                    w_state_nxt = EVAL;
                    w_sample_to = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            MEASURE: begin
                if (r_cnt == c_timeout) begin
                    w_state_nxt = EVAL;
                    w_sample_to = 1'b1;
                end else if (!r_echo_s) begin
                    w_state_nxt = EVAL;
                    w_sample_ok = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            EVAL: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_50M) begin
        if (reset) begin
            r_state        <= IDLE;
            r_cnt          <= '0;
            r_period_cnt   <= '0;
            r_first        <= 1'b1;
            r_echo_width   <= '0;
            r_width_valid  <= 1'b0;
            r_echo_timeout <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_cnt          <= w_cnt_nxt;
            r_width_valid  <= w_sample_ok;
            r_echo_timeout <= w_sample_to;
            if (w_trig_start) begin
                r_first      <= 1'b0;
                r_period_cnt <= '0;
            end else if (r_period_cnt != c_period_last) begin
                r_period_cnt <= r_period_cnt + 1'b1;
            end
            if (w_sample_ok) begin
                r_echo_width <= r_cnt;
            end
        end
    end

    // ------------------------------------------------------------------
    // Near/far detector with hysteresis and N-sample confirmation
    // ------------------------------------------------------------------
    det_state_t        r_det;
    det_state_t        w_det_nxt;
    logic [CONF_W-1:0] r_conf;
    logic [CONF_W-1:0] w_conf_nxt;
    logic              w_near;
    logic              w_far;
    logic              w_opposing;
    logic              w_fault;
    logic              r_fault_detect;
    logic [3:0]        r_fault_count;

    assign w_near = (r_echo_width < c_near);
    assign w_far  = (r_echo_width >= c_far);

    always_comb begin
        w_det_nxt  = r_det;
        w_conf_nxt = r_conf;
        w_opposing = 1'b0;
        w_fault    = 1'b0;
        if (r_width_valid) begin
            w_opposing = (r_det == FAR) ? w_near : w_far;
            if (w_opposing) begin
                if (r_conf == c_conf_last) begin
                    w_det_nxt  = (r_det == FAR) ? NEAR : FAR;
                    w_conf_nxt = '0;
                    w_fault    = (r_det == FAR);
                end else begin
                    w_conf_nxt = r_conf + 1'b1;
                end
            end else begin
                // Neutral or same-state samples break the confirmation run.
                w_conf_nxt = '0;
            end
        end
    end

    always_ff @(posedge clk_50M) begin
        if (reset) begin
            r_det          <= FAR;
            r_conf         <= '0;
            r_fault_detect <= 1'b0;
            r_fault_count  <= 4'd0;
        end else begin
            r_det          <= w_det_nxt;
            r_conf         <= w_conf_nxt;
            r_fault_detect <= w_fault;
            if (w_fault) begin
                r_fault_count <= (r_fault_count == 4'd9) ? 4'd0 : r_fault_count + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Report streamer; the request is the fault strobe itself, paired with
    // the already-incremented count.
    // ------------------------------------------------------------------
    msg_streamer #(
        .PREFIX_LEN (PREFIX_LEN)
    ) u_msg_streamer (
        .clk        (clk_50M),
        .rst        (reset),
        .i_req      (r_fault_detect),
        .i_count    (r_fault_count),
        .i_ready    (msg_ready),
        .o_data     (msg_data),
        .o_valid    (msg_valid),
        .o_busy     (msg_busy),
        .o_overflow (msg_overflow)
    );

    assign UV_trig      = (r_state == TRIG);
    assign echo_width   = r_echo_width;
    assign width_valid  = r_width_valid;
    assign echo_timeout = r_echo_timeout;
    assign in_box       = (r_det == NEAR);
    assign fault_detect = r_fault_detect;
    assign fault_count  = r_fault_count;

endmodule : us_fault_monitor
`default_nettype wire

// File: doc/us_fault_monitor.md
Name: us_fault_monitor

Overview:
Parametrised ultrasonic ranging and fault-detection block for the bot's side sensor. It does four things:
- Schedules HC-SR04-style trigger pulses at a fixed repetition rate.
- Measures echo width and applies a timeout.
- Classifies each sample near/far using hysteresis and N-sample confirmation.
- On each confirmed far->near edge, pulses fault_detect and streams an ASCII report to the Bluetooth UART through a valid/ready byte interface.

Parameters:
TRIG_CYCLES, 500, trigger high time in clocks (10 us at 50 MHz)
PERIOD_CYCLES, 3000000, trigger-start to trigger-start spacing (60 ms)
TIMEOUT_CYCLES, 1200000, max wait for echo rise, and max echo high time
CNT_W, 22, width of all cycle counters and echo_width
NEAR_THRESH, 16500, echo width strictly below this = near sample
FAR_THRESH, 18000, echo width at or above this = far sample; must be > NEAR_THRESH
CONFIRM, 2, consecutive qualifying samples needed to change state (>=1)
PREFIX_LEN, 8, number of prefix bytes taken from the package constant

Ports:
clk_50M  in  1  system clock, 50 MHz
reset  in  1  synchronous, active-high reset
UV_echo  in  1  asynchronous echo from sensor
UV_trig  out  1  trigger to sensor
echo_width  out  CNT_W  last valid echo width in clocks
width_valid  out  1  1-cycle strobe when echo_width updates
echo_timeout  out  1  1-cycle strobe on a timed-out measurement
in_box  out  1  debounced near state
fault_detect  out  1  1-cycle strobe on confirmed far->near
fault_count  out  4  faults seen, decimal 0-9, wraps 9->0
msg_data  out  8  report byte
msg_valid  out  1  msg_data valid
msg_ready  in  1  consumer accepts byte when valid & ready
msg_busy  out  1  report in progress or pending
msg_overflow  out  1  sticky: a report request was dropped

Behaviour:
- Reset values: all outputs 0; ranger FSM in IDLE with its period counter cleared; detector in FAR; confirm counter 0; streamer idle with no pending request. Reset mid-measurement or mid-report aborts immediately.
- UV_echo passes through a 2-flop synchroniser. All timing below uses the synchronised echo (echo_s).
- Ranger FSM states:
  - IDLE: the period counter runs continuously from the last trigger start. Go to TRIG when it reaches PERIOD_CYCLES-1, or on the first cycle after reset.
  - TRIG: UV_trig=1 for exactly TRIG_CYCLES cycles, then go to WAIT_RISE.
  - WAIT_RISE: on echo_s=1 go to MEASURE. After TIMEOUT_CYCLES cycles go to EVAL flagged as timeout.
  - MEASURE: the width counter increments each cycle while echo_s=1. On echo_s=0 go to EVAL. When the counter reaches TIMEOUT_CYCLES go to EVAL flagged as timeout.
  - EVAL: one cycle, then IDLE.
    - Valid sample: echo_width<=width, width_valid=1.
    - Timeout: echo_timeout=1, echo_width holds its previous value, and the detector ignores the sample.
- If the period expires before EVAL, the next TRIG starts on the cycle after EVAL, and the period counter restarts at trigger start.
- Detector, updated on each width_valid:
  - Classification: near if width<NEAR_THRESH; far if width>=FAR_THRESH; otherwise neutral.
  - Neutral samples and samples matching the current state clear the confirm counter.
  - An opposing sample increments the counter. On reaching CONFIRM the state toggles and the counter clears.
  - The FAR->NEAR toggle (in_box rises) asserts fault_detect for one cycle and fault_count increments mod 10, both in the cycle after width_valid. This cycle also raises the report request.
  - NEAR->FAR only clears in_box.
- Streamer, sub-module msg_streamer:
  - Report bytes: PREFIX[0..PREFIX_LEN-1], then 8'h30+fault_count (value after the increment), then 8'h23 '#'. That is PREFIX_LEN+2 bytes.
  - When idle with a request, msg_valid rises in the next cycle.
  - msg_data is stable while msg_valid && !msg_ready.
  - Handshake: one byte advances per valid&ready cycle, with no bubbles between bytes while ready stays high. msg_valid drops the cycle after the '#' handshake.
  - A request arriving while busy sets a single pending slot. The pending report starts the cycle after the current one ends, using the fault_count latched at request time.
  - A request arriving while busy with the pending slot already set is dropped and sets msg_overflow; only reset clears msg_overflow.
  - msg_busy = active | pending.
- Simultaneous events: a request in the same cycle as the final '#' handshake goes to pending (not dropped) and starts next cycle.

Decomposition:
- Package us_fault_pkg holds:
  - the ranger FSM enum (IDLE, TRIG, WAIT_RISE, MEASURE, EVAL);
  - the detector enum (FAR, NEAR);
  - ASCII constants (ASCII_0=8'h30, ASCII_HASH=8'h23);
  - the prefix byte array "FIM-CSU1" (46 49 4D 2D 43 53 55 31).
- One sub-module, msg_streamer: byte sequencer, pending slot and overflow flag.

Test Plan:
- Reset released, echo held 0: UV_trig high exactly 500 cycles. echo_timeout strobes 1,200,000 cycles after the trigger falls. The next trigger rises 3,000,000 cycles after the first.
- Echo pulse of 10,000 cycles twice (CONFIRM=2) -> width_valid twice with echo_width=10000. After the second sample: in_box=1, fault_detect a single pulse, fault_count=1.
- Echo widths 20000, 17000, 20000 from NEAR state -> only the 20000 samples count, and the neutral 17000 breaks confirmation, so in_box stays 1. A further 20000 then clears in_box.
- First fault with msg_ready=1 -> bytes 46 49 4D 2D 43 53 55 31 31 23 on consecutive cycles; msg_valid low afterwards.
- msg_ready toggled 0/1 each cycle -> same 10 bytes, each held stable while not ready, no byte skipped or repeated.
- Three faults during one report with msg_ready=0 -> second queued and later sends digit '2'; third dropped, msg_overflow=1; reset mid-report -> msg_valid=0, msg_overflow=0 next cycle.
